// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the wait-state memory responder.
// Imported by the bus interface, the storage bank and the top.
package MemRespPkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    RespIdle,
    RespWait,
    RespResp
  } resp_state_e;

  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Valid/ready request/response bus between a CPU port and memory.
// master = initiator (CPU), slave = responder (memory).
interface mem_responder_if;
  import MemRespPkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    output req_be,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    input  req_be,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err
  );

endinterface

// File: rtl/mem_responder_mem_bank.sv
// Word array with byte-lane writes and a registered read port.
// Read is read-first: a same-edge write is not visible on rdata.
module mem_bank
  import MemRespPkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[idx] <= byte_merge(r_mem[idx], wdata, be);
    rdata <= r_mem[idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, serviced after a
// programmable wait-state latency, with misalign/range error flag.
module mem_responder
  import MemRespPkg::*;
#(
  parameter int MEM_DEPTH     = 1024,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  mem_responder_if.slave   bus
);

  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ?
                           READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0] RD_LAT = CNT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0] WR_LAT = CNT_W'(WRITE_LATENCY);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [29:0]      DEPTH_W = 30'(MEM_DEPTH);

  resp_state_e r_state;
  resp_state_e w_next;

  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic              r_err;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;

  logic              w_idle;
  logic              w_accept;
  logic              w_enter_resp;
  logic [29:0]       w_req_idx;
  logic              w_req_err;
  logic [CNT_W-1:0]  w_lat;

  logic              w_cur_we;
  logic              w_cur_err;
  logic [IDX_W-1:0]  w_cur_idx;
  logic [DATA_W-1:0] w_cur_wdata;
  logic [BE_W-1:0]   w_cur_be;
  logic              w_bank_we;
  logic [DATA_W-1:0] w_bank_rdata;

  assign w_idle    = (r_state == RespIdle);
  assign w_accept  = bus.req_valid && w_idle;
  assign w_req_idx = bus.req_addr[31:2];
  assign w_req_err = (|bus.req_addr[1:0]) || (w_req_idx >= DEPTH_W);
  assign w_lat     = bus.req_we ? WR_LAT : RD_LAT;

  always_comb begin
    w_next       = r_state;
    w_enter_resp = 1'b0;
    unique case (r_state)
      RespIdle: begin
        if (w_accept) begin
          if (w_lat > ONE) begin
            w_next = RespWait;
          end else begin
            w_next       = RespResp;
            w_enter_resp = 1'b1;
          end
        end
      end
      RespWait: begin
        if (r_cnt == ONE) begin
          w_next       = RespResp;
          w_enter_resp = 1'b1;
        end
      end
      RespResp: begin
        if (bus.resp_ready) w_next = RespIdle;
      end
      default: w_next = RespIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RespIdle;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= w_lat - ONE;
        r_we    <= bus.req_we;
        r_err   <= w_req_err;
        r_idx   <= w_req_idx[IDX_W-1:0];
        r_wdata <= bus.req_wdata;
        r_be    <= bus.req_be;
      end else if (r_state == RespWait) begin
        r_cnt <= r_cnt - ONE;
      end
    end
  end

  // Single-cycle latency commits on the accept edge, before the latch.
  assign w_cur_we    = w_idle ? bus.req_we    : r_we;
  assign w_cur_err   = w_idle ? w_req_err     : r_err;
  assign w_cur_idx   = w_idle ? w_req_idx[IDX_W-1:0] : r_idx;
  assign w_cur_wdata = w_idle ? bus.req_wdata : r_wdata;
  assign w_cur_be    = w_idle ? bus.req_be    : r_be;

  assign w_bank_we = w_enter_resp && w_cur_we &&
                     !w_cur_err && !reset;

  mem_bank #(
    .DEPTH (MEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_bank (
    .clk   (clk),
    .we    (w_bank_we),
    .be    (w_cur_be),
    .idx   (w_cur_idx),
    .wdata (w_cur_wdata),
    .rdata (w_bank_rdata)
  );

  assign bus.req_ready  = w_idle;
  assign bus.resp_valid = (r_state == RespResp);
  assign bus.resp_err   = (r_state == RespResp) && r_err;
  assign bus.resp_rdata =
    ((r_state == RespResp) && !r_we && !r_err) ?
    w_bank_rdata : '0;

endmodule
